ehgu_fifo_rd_prefetch: RTL and testbench

Read-side prefetch stage that sits directly downstream of the FIFO pointer logic and its memory, in the read clock domain. It issues pop requests to the FIFO and absorbs the fixed memory read latency. It buffers the returned words in a small register queue and presents them to a consumer over a valid/ready handshake with backpressure. Credit-based issue guarantees that the queue never overflows.

---
 rtl/ehgu_basic_pkg.sv | 16 +
 rtl/ehgu_reg_queue.sv | 70 +++++++
 rtl/ehgu_fifo_rd_prefetch.sv | 95 +++++++++
 tb/tb_ehgu_fifo_rd_prefetch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ehgu_basic_pkg.sv
// Shared helpers for the ehgu read-side blocks: counter width derivation and
// the per-stage bookkeeping carried alongside each outstanding pop request.
package ehgu_basic_pkg;

   // Counter width able to hold 0..depth inclusive.
   function automatic int ehgu_cw(input int depth);
      return $clog2(depth + 1);
   endfunction

   // One slot of the in-flight shift register.
   typedef struct packed {
      logic expected;   // a pop was issued and its data is due when this slot exits
      logic discard;    // a flush happened after issue; drop the return silently
   } rd_stage_t;

endpackage

// File: rtl/ehgu_reg_queue.sv
// Flop-based circular queue with a show-ahead head. Pointers wrap modulo
// DEPTH, so non-power-of-two depths are fine. A push into a full queue is
// accepted only when a pop frees a slot in the same cycle.
module ehgu_reg_queue
   import ehgu_basic_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3,
   localparam int CW = ehgu_cw(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Next-state: write at tail, advance head, track count.
   always_comb begin
      do_pop   = pop & (count_q != '0);
      do_push  = push & ((count_q != CW'(DEPTH)) | do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   // Data storage carries no reset; validity comes from count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Pointer and count registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/ehgu_fifo_rd_prefetch.sv
// Read-side prefetch: issues pops to the FIFO under a credit limit, tracks the
// fixed memory latency with a shift register, lands returns in a small queue
// and presents them over valid/ready. Flush empties the queue and marks every
// outstanding return for silent discard.
module ehgu_fifo_rd_prefetch
   import ehgu_basic_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int RD_LATENCY = 1,
   parameter int BUF_DEPTH  = 3,
   localparam int CW = ehgu_cw(BUF_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             rd_empty,
   output logic             rd_req,
   input  logic [WIDTH-1:0] rd_data,
   input  logic             rd_data_valid,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [CW-1:0]    occupancy,
   output logic             err
);

   rd_stage_t [RD_LATENCY-1:0] pipe_q, pipe_d;
   logic [CW-1:0]              inflight_q, inflight_d;
   logic                       err_q, err_d;
   logic [CW-1:0]              occ;
   logic                       expected, discarded, credit_ok, q_full;
   logic                       pop, ret_ok, push, overflow, q_rst;

   // Issue, return and error decisions for the current cycle.
   always_comb begin
      expected  = pipe_q[RD_LATENCY-1].expected;
      discarded = pipe_q[RD_LATENCY-1].discard;
      // Registered occ/inflight make the credit check conservative by one cycle.
      credit_ok = ({1'b0, occ} + {1'b0, inflight_q}) < (CW + 1)'(BUF_DEPTH);
      rd_req    = en & ~rst & ~flush & ~rd_empty & credit_ok;
      q_full    = (occ == CW'(BUF_DEPTH));
      pop       = dout_valid & dout_ready;
      ret_ok    = rd_data_valid & expected & ~discarded;
      push      = ret_ok & ~flush & (~q_full | pop);
      overflow  = ret_ok & ~flush & q_full & ~pop;
      q_rst     = rst | flush;

      pipe_d             = '0;
      pipe_d[0].expected = rd_req;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      // Everything still travelling toward us, including a same-cycle issue, is stale.
      if (flush) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_d[i].discard = 1'b1;
         end
      end

      inflight_d = inflight_q + CW'(rd_req) - CW'(expected);
      err_d      = err_q | (rd_data_valid ^ expected) | overflow;
   end

   // In-flight tracking and sticky error state.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_q     <= '0;
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         pipe_q     <= pipe_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   ehgu_reg_queue #(
      .WIDTH (WIDTH),
      .DEPTH (BUF_DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (q_rst),
      .push  (push),
      .pop   (pop),
      .din   (rd_data),
      .dout  (dout),
      .count (occ)
   );

   assign dout_valid = (occ != '0);
   assign occupancy  = occ;
   assign err        = err_q;

endmodule

// File: tb/tb_ehgu_fifo_rd_prefetch.sv
// Directed bench: a queue-level model of the prefetch stage (expected words,
// outstanding returns, sticky error) is checked every cycle, plus literal
// expectations at key points. A second instance covers the shallow-buffer case.
module tb_ehgu_fifo_rd_prefetch;

   localparam int D1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 1: RD_LATENCY=1, BUF_DEPTH=3
   logic       rst, en, flush, rd_empty, rd_req, rd_data_valid;
   logic       dout_valid, dout_ready, err;
   logic [7:0] rd_data, dout;
   logic [1:0] occupancy;

   ehgu_fifo_rd_prefetch #(.WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(3)) dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .rd_empty(rd_empty),
      .rd_req(rd_req), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .occupancy(occupancy), .err(err));

   // Instance 2: RD_LATENCY=1, BUF_DEPTH=2
   logic       rst2, en2, flush2, rd_empty2, rd_req2, rd_data_valid2;
   logic       dout_valid2, dout_ready2, err2;
   logic [7:0] rd_data2, dout2;
   logic [1:0] occupancy2;

   ehgu_fifo_rd_prefetch #(.WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(2)) dut2 (
      .clk(clk), .rst(rst2), .en(en2), .flush(flush2), .rd_empty(rd_empty2),
      .rd_req(rd_req2), .rd_data(rd_data2), .rd_data_valid(rd_data_valid2),
      .dout(dout2), .dout_valid(dout_valid2), .dout_ready(dout_ready2),
      .occupancy(occupancy2), .err(err2));

   int checks = 0;
   int errors = 0;

   // Model of instance 1 plus the FIFO/memory it talks to.
   int         mq[$];        // words the consumer must see, in order
   bit         m_err;
   bit         pend_v;       // a pop issued last cycle returns this cycle
   logic [7:0] pend_d;
   int         next_val, fifo_cnt, n_req, n_pop;
   bit         spur, started;

   // Model / memory for instance 2.
   bit         p2_v;
   logic [7:0] p2_d;
   int         nv2, exp2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply();
      rd_empty      = (fifo_cnt == 0);
      rd_data_valid = pend_v | spur;
      rd_data       = pend_v ? pend_d : 8'hEE;
   endtask

   // One clock of instance 1: check outputs mid-cycle, then advance the model.
   task automatic cycle();
      bit exp_req, req_c, pop_c, rdv_c, exp_c, rst_c, flush_c;
      logic [7:0] rdd_c;
      apply();
      #1;
      exp_req = en && !rst && !flush && (fifo_cnt != 0) && ((mq.size() + int'(pend_v)) < D1);
      if (started) begin
         chk("rd_req", rd_req, exp_req);
         chk("dout_valid", dout_valid, mq.size() != 0);
         chk("occupancy", occupancy, mq.size());
         chk("err", err, m_err);
         if (mq.size() != 0) chk("dout", dout, mq[0]);
      end
      req_c   = (rd_req === 1'b1);
      pop_c   = (dout_valid === 1'b1) && dout_ready;
      rdv_c   = rd_data_valid;
      rdd_c   = rd_data;
      exp_c   = pend_v;
      rst_c   = rst;
      flush_c = flush;
      @(posedge clk);
      if (rst_c) begin
         mq.delete();
         m_err   = 1'b0;
         pend_v  = 1'b0;
         started = 1'b1;
      end else begin
         if (rdv_c != exp_c) m_err = 1'b1;
         if (flush_c) mq.delete();
         else begin
            if (pop_c) begin
               void'(mq.pop_front());
               n_pop++;
            end
            if (rdv_c && exp_c) begin
               if (mq.size() >= D1) m_err = 1'b1;
               else mq.push_back(int'(rdd_c));
            end
         end
         pend_v = req_c;
         if (req_c) begin
            pend_d = 8'(next_val);
            next_val++;
            fifo_cnt--;
            n_req++;
         end
      end
      #1;
   endtask

   // One clock of instance 2 with consumer always ready: order and error checks.
   task automatic cycle2(output bit vld);
      bit r, rs;
      rd_data_valid2 = p2_v;
      rd_data2       = p2_d;
      #1;
      vld = (dout_valid2 === 1'b1);
      if (!rst2) begin
         chk("d2_err", err2, 0);
         chk("d2_occ_bound", occupancy2 <= 2'd2, 1);
         if (dout_valid2 === 1'b1) begin
            chk("d2_order", dout2, 8'(exp2));
            exp2++;
         end
      end
      r  = (rd_req2 === 1'b1);
      rs = rst2;
      @(posedge clk);
      p2_v = r;
      if (r) begin
         p2_d = 8'(nv2);
         nv2++;
      end
      if (rs) exp2 = nv2;
      #1;
   endtask

   initial begin
      bit v;
      int nvld;
      rst = 1; en = 0; flush = 0; dout_ready = 0; spur = 0;
      fifo_cnt = 0; next_val = 0; n_req = 0; n_pop = 0;
      pend_v = 0; pend_d = 0; m_err = 0; started = 0;
      rst2 = 1; en2 = 0; flush2 = 0; rd_empty2 = 0; dout_ready2 = 1;
      rd_data_valid2 = 0; rd_data2 = 0; p2_v = 0; p2_d = 0; nv2 = 0; exp2 = 0;

      // Reset state
      repeat (2) cycle();
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_err", err, 0);
      chk("rst_rd_req", rd_req, 0);

      // Streaming at full rate, then backpressure from cycle 4
      rst = 0; en = 1; dout_ready = 1; fifo_cnt = 1000; next_val = 0;
      apply(); #1;
      chk("t1_req_c0", rd_req, 1);
      chk("t1_dv_c0", dout_valid, 0);
      cycle();
      apply(); #1;
      chk("t1_dv_c1", dout_valid, 0);
      cycle();
      apply(); #1;
      chk("t1_dv_c2", dout_valid, 1);
      chk("t1_dout_c2", dout, 8'h00);
      cycle();
      apply(); #1;
      chk("t1_dout_c3", dout, 8'h01);
      cycle();
      dout_ready = 0;
      repeat (4) cycle();
      apply(); #1;
      chk("t2_occ_full", occupancy, 3);
      chk("t2_req_stop", rd_req, 0);
      chk("t2_dout_hold", dout, 8'h02);
      dout_ready = 1;
      repeat (8) cycle();

      // Exactly five words available in the FIFO
      rst = 1; cycle();
      rst = 0; fifo_cnt = 5; next_val = 0; n_req = 0; n_pop = 0;
      repeat (12) cycle();
      chk("t3_req_count", n_req, 5);
      chk("t3_pop_count", n_pop, 5);
      chk("t3_dv_end", dout_valid, 0);
      chk("t3_occ_end", occupancy, 0);

      // Flush with occ=2 and one return in flight
      rst = 1; cycle();
      rst = 0; dout_ready = 0; fifo_cnt = 1000; next_val = 0;
      repeat (3) cycle();
      flush = 1;
      apply(); #1;
      chk("t4_occ_pre", occupancy, 2);
      cycle();
      flush = 0; dout_ready = 1;
      apply(); #1;
      chk("t4_dv_post", dout_valid, 0);
      chk("t4_err_post", err, 0);
      repeat (2) cycle();
      apply(); #1;
      chk("t4_first_after", dout, 8'h03);
      repeat (4) cycle();

      // Spurious return with nothing outstanding
      en = 0;
      repeat (4) cycle();
      spur = 1; cycle();
      spur = 0;
      apply(); #1;
      chk("t5_err_set", err, 1);
      chk("t5_occ_same", occupancy, 0);
      repeat (3) cycle();
      rst = 1; cycle();
      rst = 0;
      apply(); #1;
      chk("t5_err_cleared", err, 0);

      // Shallow buffer: bubbles but no overflow, then reset mid-stream
      repeat (2) cycle2(v);
      rst2 = 0; en2 = 1;
      repeat (6) cycle2(v);
      nvld = 0;
      repeat (12) begin
         cycle2(v);
         nvld += int'(v);
      end
      chk("d2_has_bubbles", nvld < 12, 1);
      chk("d2_at_least_half", nvld >= 6, 1);
      rst2 = 1; cycle2(v);
      rst2 = 0;
      rd_data_valid2 = p2_v; #1;
      chk("d2_rst_occ", occupancy2, 0);
      chk("d2_rst_dv", dout_valid2, 0);
      repeat (8) cycle2(v);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
